// File: rtl/px_to_cols_mc_if.sv
// AXI4-Stream bundle used by px_to_cols_mc.
// The master drives the payload; the slave returns tready.
interface axi4_stream_if #(
  parameter int DW = 8
);
  logic            tvalid;
  logic            tready;
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tkeep;
  logic [DW/8-1:0] tstrb;
  logic            tuser;
  logic            tlast;

  modport master (
    output tvalid, tdata, tkeep, tstrb,
    output tuser, tlast,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tstrb,
    input  tuser, tlast,
    output tready
  );
endinterface

// File: rtl/px_to_cols_mc.sv
// Multi-channel pixel-to-column converter.
// Ping-pong block buffers, one column or row per output beat.
module px_to_cols_mc #(
  parameter int PX_WIDTH = 8,
  parameter int MAT_SIZE = 8,
  parameter int N_CH     = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          col_mode_i,
  axi4_stream_if.slave  video_i,
  axi4_stream_if.master video_o,
  output logic          busy_o
);
  localparam int MAT_ELEMS = MAT_SIZE * MAT_SIZE;
  localparam int PXG_W  = N_CH * PX_WIDTH;
  localparam int BEAT_W = N_CH * MAT_SIZE * PX_WIDTH;
  localparam int OW     = ((BEAT_W + 7) / 8) * 8;
  localparam int CW     = $clog2(MAT_SIZE);
  localparam int AW     = 2 * CW;

  typedef enum logic [1:0] {
    WR0, WR1, WAIT_FREE
  } wr_state_e;

  typedef enum logic [1:0] {
    IDLE, RD0, RD1
  } rd_state_e;

  wr_state_e wr_state_q, wr_state_d;
  logic      wr_buf_q, wr_buf_d;
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;

  rd_state_e rd_state_q, rd_state_d;
  logic      rd_nxt_q;
  logic [CW-1:0] rd_cnt_q;

  logic [1:0] full_q;
  logic [1:0] mode_q;
  logic [1:0] user_q;
  logic [1:0] last_q;
  logic [PXG_W-1:0] mem_q [2][MAT_ELEMS];

  logic          out_valid_q;
  logic          out_user_q;
  logic          out_last_q;
  logic          out_end_q;
  logic          out_buf_q;
  logic [OW-1:0] out_data_q;

  logic in_ready, in_hs, wr_first, wr_end;
  logic rd_act, rd_sel, ld_en, rd_ld, rd_end;
  logic rel;
  logic [BEAT_W-1:0] beat_w;
  logic unused_in;

  assign in_hs    = video_i.tvalid & in_ready;
  assign wr_first = (wr_cnt_q == '0);
  assign wr_end   = in_hs
                  & (wr_cnt_q == AW'(MAT_ELEMS - 1));

  // Write FSM outputs: accept only into a free buffer
  always_comb begin
    in_ready = 1'b0;
    unique case (wr_state_q)
      WR0:     in_ready = !full_q[0];
      WR1:     in_ready = !full_q[1];
      default: in_ready = 1'b0;
    endcase
  end

  // Write FSM next state: swap buffers at block end
  always_comb begin
    wr_state_d = wr_state_q;
    wr_buf_d   = wr_buf_q ^ wr_end;
    wr_cnt_d   = in_hs ? wr_cnt_q + AW'(1) : wr_cnt_q;
    unique case (wr_state_q)
      WR0, WR1: begin
        if (wr_end) begin
          if (full_q[~wr_buf_q])
            wr_state_d = WAIT_FREE;
          else
            wr_state_d = wr_buf_q ? WR0 : WR1;
        end
      end
      WAIT_FREE: begin
        if (!full_q[wr_buf_q])
          wr_state_d = wr_buf_q ? WR1 : WR0;
      end
      default: wr_state_d = WR0;
    endcase
  end

  // Write FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_state_q <= WR0;
      wr_buf_q   <= 1'b0;
      wr_cnt_q   <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_buf_q   <= wr_buf_d;
      wr_cnt_q   <= wr_cnt_d;
    end
  end

  // Capture pixel groups into the buffer being filled
  always_ff @(posedge clk_i) begin
    if (in_hs)
      mem_q[wr_buf_q][wr_cnt_q] <= video_i.tdata[PXG_W-1:0];
  end

  // Per-buffer flags: fill completion, mode, side-band, release
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full_q <= '0;
      mode_q <= '0;
      user_q <= '0;
      last_q <= '0;
    end else begin
      if (rel) begin
        full_q[out_buf_q] <= 1'b0;
        user_q[out_buf_q] <= 1'b0;
        last_q[out_buf_q] <= 1'b0;
      end
      if (in_hs) begin
        if (wr_first) begin
          mode_q[wr_buf_q] <= col_mode_i;
          user_q[wr_buf_q] <= video_i.tuser;
          last_q[wr_buf_q] <= video_i.tlast;
        end else begin
          user_q[wr_buf_q] <= user_q[wr_buf_q]
                            | video_i.tuser;
          last_q[wr_buf_q] <= last_q[wr_buf_q]
                            | video_i.tlast;
        end
        if (wr_end)
          full_q[wr_buf_q] <= 1'b1;
      end
    end
  end

  // Read FSM outputs: which buffer is draining
  always_comb begin
    rd_act = 1'b0;
    rd_sel = 1'b0;
    unique case (rd_state_q)
      RD0: rd_act = 1'b1;
      RD1: begin
        rd_act = 1'b1;
        rd_sel = 1'b1;
      end
      default: ;
    endcase
  end

  assign ld_en  = !out_valid_q | video_o.tready;
  assign rd_ld  = rd_act & ld_en;
  assign rd_end = rd_ld
                & (rd_cnt_q == CW'(MAT_SIZE - 1));
  assign rel    = out_valid_q & video_o.tready
                & out_end_q;

  // Read FSM next state: strict buffer alternation
  always_comb begin
    rd_state_d = rd_state_q;
    unique case (rd_state_q)
      IDLE: begin
        if (full_q[rd_nxt_q])
          rd_state_d = rd_nxt_q ? RD1 : RD0;
      end
      RD0, RD1: begin
        if (rd_end)
          rd_state_d = IDLE;
      end
      default: rd_state_d = IDLE;
    endcase
  end

  // Read FSM state register and beat counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_state_q <= IDLE;
      rd_nxt_q   <= 1'b0;
      rd_cnt_q   <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      if (rd_end)
        rd_nxt_q <= ~rd_nxt_q;
      if (rd_ld)
        rd_cnt_q <= rd_cnt_q + CW'(1);
    end
  end

  for (genvar i = 0; i < MAT_SIZE; i++) begin : g_lane
    localparam logic [CW-1:0] LI = CW'(i);
    logic [AW-1:0]    idx;
    logic [PXG_W-1:0] px;
    assign idx = mode_q[rd_sel] ? {LI, rd_cnt_q}
                                : {rd_cnt_q, LI};
    assign px  = mem_q[rd_sel][idx];
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
      assign beat_w[(c*MAT_SIZE+i)*PX_WIDTH +: PX_WIDTH] =
        px[c*PX_WIDTH +: PX_WIDTH];
    end
  end

  // Output register: holds a beat until accepted
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_user_q  <= 1'b0;
      out_last_q  <= 1'b0;
      out_end_q   <= 1'b0;
      out_buf_q   <= 1'b0;
      out_data_q  <= '0;
    end else if (ld_en) begin
      out_valid_q <= rd_act;
      if (rd_act) begin
        out_data_q <= OW'(beat_w);
        out_user_q <= user_q[rd_sel]
                    & (rd_cnt_q == '0);
        out_last_q <= last_q[rd_sel]
                    & (rd_cnt_q == CW'(MAT_SIZE - 1));
        out_end_q  <= (rd_cnt_q == CW'(MAT_SIZE - 1));
        out_buf_q  <= rd_sel;
      end else begin
        out_user_q <= 1'b0;
        out_last_q <= 1'b0;
        out_end_q  <= 1'b0;
      end
    end
  end

  assign video_i.tready = in_ready;
  assign video_o.tvalid = out_valid_q;
  assign video_o.tdata  = out_data_q;
  assign video_o.tuser  = out_user_q;
  assign video_o.tlast  = out_last_q;
  assign video_o.tkeep  = '1;
  assign video_o.tstrb  = '1;
  assign busy_o = (|full_q) | (wr_cnt_q != '0);

  assign unused_in = ^{video_i.tkeep, video_i.tstrb,
                       video_i.tdata};
endmodule

// File: tb/tb_px_to_cols_mc.sv
// Bench for px_to_cols_mc: directed blocks,
// queue scoreboard checked by an output monitor.
module tb_px_to_cols_mc;
  localparam int PW = 8;
  localparam int MS = 8;
  localparam int NC = 3;
  localparam int ME = MS * MS;
  localparam int IW = 24;
  localparam int OW = 192;

  typedef struct packed {
    logic [OW-1:0] d;
    logic          u;
    logic          l;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic col_mode = 1'b0;
  logic busy;

  always #5 clk = ~clk;

  axi4_stream_if #(.DW(IW)) vin ();
  axi4_stream_if #(.DW(OW)) vout ();

  px_to_cols_mc #(
    .PX_WIDTH(PW),
    .MAT_SIZE(MS),
    .N_CH(NC)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .col_mode_i(col_mode),
    .video_i(vin),
    .video_o(vout),
    .busy_o(busy)
  );

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_in_cyc = 0;
  int   first_valid_cyc = -1;
  int   hs_cyc[$];
  bit   chk_drop = 0;
  int   drops = 0;
  bit   stall_q = 0;
  logic [OW+1:0] held;
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm,
                       input logic [255:0] got,
                       input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h",
               nm, got, exp);
    end
  endtask

  function automatic logic [7:0] pxv(int c, int r,
                                     int col, int off);
    return 8'((64*c + 8*r + col + off) & 255);
  endfunction

  task automatic push_block(int off, bit mode,
                            bit u, bit l);
    for (int j = 0; j < MS; j++) begin
      exp_t e;
      e.d = '0;
      for (int i = 0; i < MS; i++)
        for (int c = 0; c < NC; c++)
          e.d[(c*MS+i)*PW +: PW] =
            mode ? pxv(c, i, j, off) : pxv(c, j, i, off);
      e.u = u && (j == 0);
      e.l = l && (j == MS-1);
      sb.push_back(e);
    end
  endtask

  task automatic send_beat(input logic [IW-1:0] d,
                           input logic u,
                           input logic l);
    int n = 0;
    vin.tvalid = 1'b1;
    vin.tdata  = d;
    vin.tuser  = u;
    vin.tlast  = l;
    @(negedge clk);
    while (!vin.tready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      n_tests++;
      n_fail++;
      $display("FAIL in_timeout: tready 0, required 1");
    end
    @(posedge clk);
    #1;
  endtask

  // lm: 0 no tlast, 1 tlast on last beat, 2 every line end
  task automatic send_block(int off, bit mode, bit u,
                            int lm, int abort_at);
    if (abort_at < 0) push_block(off, mode, u, lm != 0);
    col_mode = mode;
    for (int k = 0; k < ME; k++) begin
      logic [IW-1:0] d;
      d = '0;
      for (int c = 0; c < NC; c++)
        d[c*PW +: PW] = pxv(c, k / MS, k % MS, off);
      if (k == abort_at) begin
        vin.tdata  = d;
        vin.tvalid = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        vin.tvalid = 1'b0;
        return;
      end
      send_beat(d, u && (k == 0),
                (lm == 1 && k == ME-1) ||
                (lm == 2 && (k % MS) == MS-1));
      last_in_cyc = cyc;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || vout.tvalid || busy)
           && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 3000) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d beats left, required 0",
               sb.size());
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      stall_q = 0;
    end else begin
      if (stall_q) begin
        check("hold_valid", 256'(vout.tvalid), 256'(1));
        check("hold_beat",
              256'({vout.tdata, vout.tuser, vout.tlast}),
              256'(held));
      end
      if (vout.tvalid && first_valid_cyc < 0)
        first_valid_cyc = cyc;
      if (vout.tvalid && vout.tready) begin
        hs_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL out_extra: got beat %h, required none",
                   vout.tdata);
        end else begin
          mon_e = sb.pop_front();
          check("out_data", 256'(vout.tdata), 256'(mon_e.d));
          check("out_user", 256'(vout.tuser), 256'(mon_e.u));
          check("out_last", 256'(vout.tlast), 256'(mon_e.l));
        end
      end
      stall_q = vout.tvalid && !vout.tready;
      held = {vout.tdata, vout.tuser, vout.tlast};
      if (chk_drop && vin.tvalid && !vin.tready)
        drops++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run incomplete, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vin.tvalid = 1'b0;
    vin.tdata  = '0;
    vin.tuser  = 1'b0;
    vin.tlast  = 1'b0;
    vin.tkeep  = '1;
    vin.tstrb  = '1;
    vout.tready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_tvalid", 256'(vout.tvalid), 256'(0));
    check("rst_tdata", 256'(vout.tdata), 256'(0));
    check("rst_tuser", 256'(vout.tuser), 256'(0));
    check("rst_tlast", 256'(vout.tlast), 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_in_ready", 256'(vin.tready), 256'(1));

    // column mode, latency and contiguity
    first_valid_cyc = -1;
    hs_cyc.delete();
    send_block(0, 1'b1, 1'b0, 0, -1);
    vin.tvalid = 1'b0;
    wait_drain();
    check("latency", 256'(first_valid_cyc - last_in_cyc),
          256'(2));
    if (hs_cyc.size() >= 8)
      check("contiguous", 256'(hs_cyc[7] - hs_cyc[0]),
            256'(7));
    else
      check("contig_beats", 256'(hs_cyc.size()), 256'(8));

    // row mode, then per-block mode toggles
    send_block(5, 1'b0, 1'b0, 0, -1);
    send_block(9, 1'b1, 1'b0, 0, -1);
    send_block(13, 1'b0, 1'b0, 0, -1);
    vin.tvalid = 1'b0;
    wait_drain();

    // four blocks back to back, input never stalls
    drops = 0;
    chk_drop = 1;
    for (int b = 0; b < 4; b++)
      send_block(20 + 3*b, b[0], 1'b0, 0, -1);
    chk_drop = 0;
    vin.tvalid = 1'b0;
    check("in_ready_drops", 256'(drops), 256'(0));
    wait_drain();

    // downstream stall, writer parks in WAIT_FREE
    vout.tready = 1'b0;
    send_block(40, 1'b1, 1'b0, 0, -1);
    send_block(44, 1'b0, 1'b0, 0, -1);
    fork
      send_block(48, 1'b1, 1'b0, 0, -1);
      begin
        repeat (5) @(posedge clk);
        #1;
        check("wf_in_ready", 256'(vin.tready), 256'(0));
        check("wf_in_valid", 256'(vin.tvalid), 256'(1));
        check("wf_out_valid", 256'(vout.tvalid), 256'(1));
        check("wf_busy", 256'(busy), 256'(1));
        repeat (200) @(posedge clk);
        #1;
        vout.tready = 1'b1;
      end
    join
    vin.tvalid = 1'b0;
    wait_drain();

    // side-band: tuser, tlast on last beat, tlast per line
    send_block(60, 1'b1, 1'b1, 0, -1);
    send_block(64, 1'b1, 1'b0, 1, -1);
    send_block(70, 1'b0, 1'b0, 2, -1);
    vin.tvalid = 1'b0;
    wait_drain();

    // reset mid-block while the previous block is held
    vout.tready = 1'b0;
    send_block(80, 1'b1, 1'b0, 0, -1);
    send_block(90, 1'b0, 1'b0, 0, 30);
    sb.delete();
    check("mrst_tvalid", 256'(vout.tvalid), 256'(0));
    check("mrst_tdata", 256'(vout.tdata), 256'(0));
    check("mrst_tuser", 256'(vout.tuser), 256'(0));
    check("mrst_tlast", 256'(vout.tlast), 256'(0));
    check("mrst_busy", 256'(busy), 256'(0));
    check("mrst_in_ready", 256'(vin.tready), 256'(1));
    vout.tready = 1'b1;
    send_block(100, 1'b1, 1'b1, 1, -1);
    vin.tvalid = 1'b0;
    wait_drain();
    check("sb_empty", 256'(sb.size()), 256'(0));

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end
endmodule
